// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, byte width, tag helpers.
package uart_pkg;

  localparam int unsigned ByteW = 8;

  localparam logic [3:0] TAG_HI_DEF = 4'hA;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  // Tag byte: fixed upper nibble, requester id in the lower nibble.
  function automatic logic [ByteW-1:0] make_tag(input logic [3:0] hi, input logic [3:0] id);
    return {hi, id};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request at or after ptr_i, wrapping at N.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 transmitter among NUM_REQ byte requesters with round-robin grant,
// optional requester tag byte, inter-frame gap and a launch timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter bit          ID_PREFIX = 1'b0,
  parameter logic [3:0]  TAG_HI    = TAG_HI_DEF,
  parameter int unsigned GAP_CLKS  = 0,
  parameter int unsigned BUSY_TO   = 8,
  localparam int unsigned IdxW     = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [ByteW*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     tx_valid_o,
  output logic [ByteW-1:0]         tx_din_o,
  input  logic                     tx_busy_i,
  input  logic                     tx_done_i,
  output logic [IdxW-1:0]          grant_id_o,
  output logic                     arb_busy_o,
  output logic                     launch_err_o
);

  logic [2:0]       state_q, state_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]  grant_q, grant_d;
  logic [ByteW-1:0] payload_q, payload_d;
  logic [ByteW-1:0] din_q, din_d;
  logic             tag_phase_q, tag_phase_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [15:0]      to_cnt_q, to_cnt_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;
  logic [ByteW-1:0]   pick_byte;
  logic [IdxW-1:0]    next_ptr;
  logic               to_hit;
  logic               accept;

  rr_pick #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IdxW'(i)) begin
        pick_byte = req_data_i[ByteW*i +: ByteW];
      end
    end
  end

  assign next_ptr = IdxW'((32'(grant_q) + 32'd1) % NUM_REQ);
  assign to_hit   = (to_cnt_q == 16'(BUSY_TO - 1));

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    payload_d    = payload_q;
    din_d        = din_q;
    tag_phase_d  = tag_phase_q;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    accept       = 1'b0;
    launch_err_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A still-busy transmitter (e.g. after our reset) stalls arbitration.
        if (pick_any && !tx_busy_i && !rst_i) begin
          accept      = 1'b1;
          grant_d     = pick_idx;
          payload_d   = pick_byte;
          din_d       = ID_PREFIX ? make_tag(TAG_HI, 4'(pick_idx)) : pick_byte;
          tag_phase_d = ID_PREFIX;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = S_WAIT_DONE;
        end else if (to_hit) begin
          launch_err_o = 1'b1;
          tag_phase_d  = 1'b0;
          rr_ptr_d     = next_ptr;
          state_d      = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done_i) begin
          if (tag_phase_q) begin
            tag_phase_d = 1'b0;
            din_d       = payload_q;
            state_d     = S_LAUNCH;
          end else begin
            rr_ptr_d  = next_ptr;
            gap_cnt_d = '0;
            state_d   = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 8'(GAP_CLKS - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      payload_q   <= '0;
      din_q       <= '0;
      tag_phase_q <= 1'b0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      payload_q   <= payload_d;
      din_q       <= din_d;
      tag_phase_q <= tag_phase_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign req_ready_o = accept ? pick_onehot : '0;
  assign tx_valid_o  = (state_q == S_LAUNCH);
  assign tx_din_o    = din_q;
  assign grant_id_o  = grant_q;
  assign arb_busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: plain instance (a) and tag+gap instance (b),
// each driving its own behavioural transmitter (busy 1 clk after valid, done 40 clks later).
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  a_req_valid, b_req_valid;
  logic [31:0] a_req_data, b_req_data;
  logic [3:0]  a_req_ready, b_req_ready;
  logic        a_tx_valid, b_tx_valid;
  logic [7:0]  a_tx_din, b_tx_din;
  logic [1:0]  a_grant, b_grant;
  logic        a_arb_busy, b_arb_busy, a_err, b_err;

  logic [1:0] busy_m = '0;
  logic [1:0] done_m = '0;
  logic [1:0] nobusy;
  int         cnt_m [2];
  logic [1:0] txv;
  assign txv = {b_tx_valid, a_tx_valid};

  int errors = 0;
  int checks = 0;
  int a_vcnt = 0, a_dcnt = 0, b_rdy = 0, b_viol = 0, multi = 0;
  logic [7:0] b_din_prev = '0;

  uart_tx_arbiter #(
    .NUM_REQ (4)
  ) u_dut_a (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (a_req_valid),
    .req_data_i   (a_req_data),
    .req_ready_o  (a_req_ready),
    .tx_valid_o   (a_tx_valid),
    .tx_din_o     (a_tx_din),
    .tx_busy_i    (busy_m[0]),
    .tx_done_i    (done_m[0]),
    .grant_id_o   (a_grant),
    .arb_busy_o   (a_arb_busy),
    .launch_err_o (a_err)
  );

  uart_tx_arbiter #(
    .NUM_REQ   (4),
    .ID_PREFIX (1'b1),
    .GAP_CLKS  (5)
  ) u_dut_b (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (b_req_valid),
    .req_data_i   (b_req_data),
    .req_ready_o  (b_req_ready),
    .tx_valid_o   (b_tx_valid),
    .tx_din_o     (b_tx_din),
    .tx_busy_i    (busy_m[1]),
    .tx_done_i    (done_m[1]),
    .grant_id_o   (b_grant),
    .arb_busy_o   (b_arb_busy),
    .launch_err_o (b_err)
  );

  // Transmitter models; they have no reset, like the real transmitter.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      done_m[k] <= 1'b0;
      if (busy_m[k]) begin
        if (cnt_m[k] == 38) begin
          busy_m[k] <= 1'b0;
          done_m[k] <= 1'b1;
        end else begin
          cnt_m[k] <= cnt_m[k] + 1;
        end
      end else if (txv[k] && !nobusy[k]) begin
        busy_m[k] <= 1'b1;
        cnt_m[k]  <= 0;
      end
    end
    if (a_tx_valid) a_vcnt <= a_vcnt + 1;
    if (done_m[0]) a_dcnt <= a_dcnt + 1;
    if (|b_req_ready) b_rdy <= b_rdy + 1;
    if ($countones(a_req_ready) > 1 || $countones(b_req_ready) > 1) multi <= multi + 1;
  end

  always @(negedge clk) begin
    if (busy_m[1] && b_tx_din != b_din_prev) b_viol <= b_viol + 1;
    b_din_prev <= b_tx_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (txv[k] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(input int k, output int n);
    n = 0;
    while (done_m[k] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, bad, vseen, v0, d0, r0;
    rst         = 1'b1;
    nobusy      = '0;
    a_req_valid = '0;
    b_req_valid = '0;
    a_req_data  = '0;
    b_req_data  = '0;
    repeat (3) @(negedge clk);

    chk("rst_tx_valid", {b_tx_valid, a_tx_valid}, 0);
    chk("rst_tx_din", a_tx_din, 0);
    chk("rst_grant", a_grant, 0);
    chk("rst_arb_busy", {b_arb_busy, a_arb_busy}, 0);
    chk("rst_err", {b_err, a_err}, 0);
    chk("rst_ready", {b_req_ready, a_req_ready}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single request
    a_req_data[23:16] = 8'h5a;
    a_req_valid       = 4'b0100;
    #1;
    chk("t1_ready", a_req_ready, 4'b0100);
    @(negedge clk);
    a_req_valid = '0;
    chk("t1_tx_valid", a_tx_valid, 1);
    chk("t1_din", a_tx_din, 8'h5a);
    chk("t1_grant", a_grant, 2);
    bad = 0;
    n   = 0;
    while (!done_m[0] && n < 300) begin
      @(negedge clk);
      n++;
      if (a_tx_din !== 8'h5a) bad++;
      if (n == 1) chk("t1_valid_pulse", a_tx_valid, 0);
    end
    chk("t1_done_lat", n, 40);
    chk("t1_din_hold", bad, 0);
    @(negedge clk);
    chk("t1_idle", a_arb_busy, 0);

    // 2: all four requesting continuously, fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) a_req_data[8*i +: 8] = 8'h10 + 8'(i);
    a_req_valid = 4'hf;
    #1;
    chk("t2_first_ready", a_req_ready, 4'b0001);
    v0 = a_vcnt;
    d0 = a_dcnt;
    for (int g = 0; g < 5; g++) begin
      wait_valid(0, n);
      chk("t2_latency", n, (g == 0) ? 1 : 2);
      chk("t2_grant", a_grant, g % 4);
      chk("t2_din", a_tx_din, 8'h10 + (g % 4));
      if (g == 4) a_req_valid = '0;
      wait_done(0, n);
    end
    @(negedge clk);
    chk("t2_valids", a_vcnt - v0, 5);
    chk("t2_dones", a_dcnt - d0, 5);

    // 5: transmitter never goes busy -> launch timeout, pointer still advances
    nobusy[0]         = 1'b1;
    a_req_data[15:8]  = 8'h77;
    a_req_valid       = 4'b0010;
    #1;
    chk("t5_ready", a_req_ready, 4'b0010);
    wait_valid(0, n);
    chk("t5_lat", n, 1);
    a_req_valid = 4'b0110;
    n = 0;
    while (!a_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_err_lat", n, 8);
    nobusy[0] = 1'b0;
    @(negedge clk);
    chk("t5_err_pulse", a_err, 0);
    chk("t5_idle", a_arb_busy, 0);
    chk("t5_next_ready", a_req_ready, 4'b0100);
    wait_valid(0, n);
    chk("t5_next_grant", a_grant, 2);
    a_req_valid = '0;
    wait_done(0, n);
    chk("t5_next_done", n, 40);

    // 6: reset mid-frame, then stall until the transmitter drops busy
    a_req_data[31:24] = 8'he7;
    a_req_valid       = 4'b1000;
    wait_valid(0, n);
    chk("t6_lat", n, 2);
    chk("t6_grant", a_grant, 3);
    a_req_valid = '0;
    repeat (10) @(negedge clk);
    chk("t6_in_frame", a_arb_busy, 1);
    rst              = 1'b1;
    a_req_data[7:0]  = 8'h3c;
    a_req_valid      = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_valid", a_tx_valid, 0);
    chk("t6_rst_busy", a_arb_busy, 0);
    chk("t6_rst_din", a_tx_din, 0);
    chk("t6_rst_grant", a_grant, 0);
    chk("t6_rst_ready", a_req_ready, 0);
    vseen = 0;
    n     = 0;
    while (busy_m[0] && n < 300) begin
      @(negedge clk);
      n++;
      if (a_tx_valid) vseen++;
    end
    chk("t6_no_launch_busy", vseen, 0);
    wait_valid(0, n);
    chk("t6_relaunch_lat", n, 1);
    chk("t6_relaunch_grant", a_grant, 0);
    chk("t6_relaunch_din", a_tx_din, 8'h3c);
    a_req_valid = '0;
    wait_done(0, n);

    // 3 + 4: tag prefix and inter-frame gap on instance b
    b_req_data[31:24] = 8'hc3;
    b_req_data[7:0]   = 8'h21;
    b_req_valid       = 4'b1000;
    #1;
    chk("t3_ready", b_req_ready, 4'b1000);
    r0 = b_rdy;
    wait_valid(1, n);
    chk("t3_lat", n, 1);
    chk("t3_tag", b_tx_din, 8'ha3);
    chk("t3_grant", b_grant, 3);
    b_req_valid = 4'b0001;
    wait_done(1, n);
    wait_valid(1, n);
    chk("t3_tag_to_payload", n, 1);
    chk("t3_payload", b_tx_din, 8'hc3);
    chk("t3_grant_hold", b_grant, 3);
    chk("t3_single_ready", b_rdy - r0, 1);
    wait_done(1, n);
    wait_valid(1, n);
    chk("t4_gap_lat", n, 7);
    chk("t4_tag0", b_tx_din, 8'ha0);
    chk("t4_grant", b_grant, 0);
    b_req_valid = '0;
    wait_done(1, n);
    wait_valid(1, n);
    chk("t4_payload_lat", n, 1);
    chk("t4_payload", b_tx_din, 8'h21);
    wait_done(1, n);
    @(negedge clk);
    chk("b_din_stable", b_viol, 0);
    chk("ready_onehot", multi, 0);
    chk("b_no_err", b_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
